// File: rtl/switch_ctrl_pkg.sv
// Shared FSM state encoding and default timing limits for the switch enable controller.
// Defaults assume a 25 MHz clock: 10 ms debounce, 1 s long-press threshold.
package switch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } sw_state_e;

    localparam int DEBOUNCE_LIMIT_DEF = 250000;
    localparam int HOLD_LIMIT_DEF     = 25000000;

endpackage

// File: rtl/switch_enable_ctrl_if.sv
// Push-button side of the enable controller: raw switch in, debounced level and enable/clear out.
// No handshake; all signals are levels or single-cycle pulses.
interface switch_enable_ctrl_if;

    logic i_Switch;
    logic o_Switch_Db;
    logic o_Enable;
    logic o_Clear;

    modport master (
        output i_Switch,
        input  o_Switch_Db,
        input  o_Enable,
        input  o_Clear
    );

    modport slave (
        input  i_Switch,
        output o_Switch_Db,
        output o_Enable,
        output o_Clear
    );

endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stability counter for a bouncing push-button.
// Latency: a clean level change reaches o_Switch_Db on the DEBOUNCE_LIMIT+2 rising edge.
module debounce_filter
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch_Db
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_Sync1;
    logic             r_Sync2;
    logic [CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Sync1     <= 1'b0;
            r_Sync2     <= 1'b0;
            r_Count     <= '0;
            o_Switch_Db <= 1'b0;
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
            // Any sample matching the current debounced level restarts the stability window.
            if (r_Sync2 == o_Switch_Db) begin
                r_Count <= '0;
            end else if (r_Count == CNT_MAX) begin
                o_Switch_Db <= r_Sync2;
                r_Count     <= '0;
            end else begin
                r_Count <= r_Count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_enable_ctrl.sv
// Push-button run control: short press toggles o_Enable, long press forces it low and pulses o_Clear.
// Enable/clear update one cycle after the debounced level changes or the hold limit is reached.
module switch_enable_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
    parameter int HOLD_LIMIT     = HOLD_LIMIT_DEF
) (
    input logic           i_Clk,
    input logic           i_Rst,
    switch_enable_ctrl_if.slave sw
);

    localparam int                HOLD_W   = $clog2(HOLD_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT - 1);

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_PRESSED = 2'(PRESSED);
    localparam logic [1:0] S_HELD    = 2'(HELD);

    logic              w_Switch_Db;
    logic [1:0]        r_State;
    logic [HOLD_W-1:0] r_Hold_Count;
    logic              r_Enable;
    logic              r_Clear;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Switch   (sw.i_Switch),
        .o_Switch_Db(w_Switch_Db)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State      <= S_IDLE;
            r_Hold_Count <= '0;
            r_Enable     <= 1'b0;
            r_Clear      <= 1'b0;
        end else begin
            r_Clear <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (w_Switch_Db) begin
                        r_State      <= S_PRESSED;
                        r_Hold_Count <= '0;
                    end
                end
                S_PRESSED: begin
                    if (r_Hold_Count != HOLD_MAX) begin
                        r_Hold_Count <= r_Hold_Count + 1'b1;
                    end
                    // Release is tested first so it wins when it lands on the hold limit.
                    if (!w_Switch_Db) begin
                        r_State  <= S_IDLE;
                        r_Enable <= ~r_Enable;
                    end else if (r_Hold_Count == HOLD_MAX) begin
                        r_State  <= S_HELD;
                        r_Enable <= 1'b0;
                        r_Clear  <= 1'b1;
                    end
                end
                S_HELD: begin
                    if (!w_Switch_Db) begin
                        r_State <= S_IDLE;
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    assign sw.o_Switch_Db = w_Switch_Db;
    assign sw.o_Enable    = r_Enable;
    assign sw.o_Clear     = r_Clear;

endmodule

// File: tb/tb_switch_enable_ctrl.sv
// Scoreboard bench: expected output changes are queued when a press is driven and matched on each observed change.
// Runs with DEBOUNCE_LIMIT=4, HOLD_LIMIT=20.
module tb_switch_enable_ctrl;

    localparam int DL = 4;
    localparam int HL = 20;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } evt_t;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b0;

    switch_enable_ctrl_if sw ();

    switch_enable_ctrl #(
        .DEBOUNCE_LIMIT(DL),
        .HOLD_LIMIT    (HL)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .sw   (sw)
    );

    always #5 i_Clk = ~i_Clk;

    evt_t       exp_q[$];
    evt_t       got_e;
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] prev_out;
    logic       m_en;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] cur_out();
        return {sw.o_Switch_Db, sw.o_Enable, sw.o_Clear};
    endfunction

    // Every change of {o_Switch_Db, o_Enable, o_Clear} outside reset must match the next queued expectation.
    always @(negedge i_Clk) begin
        if (i_Rst) begin
            prev_out = cur_out();
        end else if (cur_out() !== prev_out) begin
            chk("evt_queued", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                got_e = exp_q.pop_front();
                chk("evt_cyc", 32'(cyc), 32'(got_e.cyc));
                chk("evt_val", 32'(cur_out()), 32'(got_e.val));
            end
            prev_out = cur_out();
        end
    end

    task automatic step();
        @(posedge i_Clk);
        #2;
    endtask

    // Expected output trace for a press whose debounce path starts at cycle c and lasts p cycles.
    task automatic push_press(input int c, input int p, input logic en0);
        logic [2:0] last;
        logic [2:0] v;
        logic       lng;
        lng  = (p >= HL + 1);
        last = {1'b0, en0, 1'b0};
        for (int k = 0; k <= p + 10; k++) begin
            logic db;
            logic en;
            logic clr;
            db = (k >= DL + 2) && (k < p + DL + 2);
            if (lng) en = (k >= DL + HL + 3) ? 1'b0 : en0;
            else     en = (k >= p + DL + 3) ? ~en0 : en0;
            clr = lng && (k == DL + HL + 3);
            v   = {db, en, clr};
            if (v != last) begin
                exp_q.push_back('{cyc: c + k, val: v});
                last = v;
            end
        end
        m_en = lng ? 1'b0 : ~en0;
    endtask

    task automatic do_press(input int p, input bit bounce);
        if (bounce) begin
            sw.i_Switch = 1'b1;
            repeat (2) step();
            sw.i_Switch = 1'b0;
            repeat (2) step();
        end
        push_press(cyc, p, m_en);
        sw.i_Switch = 1'b1;
        repeat (p) step();
        sw.i_Switch = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        sw.i_Switch = 1'b0;
        m_en        = 1'b0;
        #1 i_Rst = 1'b1;
        repeat (3) step();
        chk("rst_db",  32'(sw.o_Switch_Db), 32'd0);
        chk("rst_en",  32'(sw.o_Enable),    32'd0);
        chk("rst_clr", 32'(sw.o_Clear),     32'd0);
        i_Rst = 1'b0;
        repeat (3) step();

        do_press(10, 1'b0);   // clean short press
        do_press(12, 1'b1);   // bounce before the real press
        do_press(8,  1'b0);
        do_press(40, 1'b0);   // long press with enable high
        do_press(40, 1'b0);   // long press with enable already low
        do_press(6,  1'b0);
        do_press(20, 1'b0);   // release coincides with hold limit
        do_press(6,  1'b0);
        do_press(21, 1'b0);   // one cycle past the coincident case
        do_press(6,  1'b0);

        // Reset in the middle of a held press with enable high.
        exp_q.push_back('{cyc: cyc + DL + 2, val: {1'b1, m_en, 1'b0}});
        sw.i_Switch = 1'b1;
        repeat (12) step();
        chk("pre_rst_en", 32'(sw.o_Enable), 32'(m_en));
        chk("pre_rst_q",  32'(exp_q.size()), 32'd0);
        i_Rst = 1'b1;
        #1;
        chk("midrst_db",  32'(sw.o_Switch_Db), 32'd0);
        chk("midrst_en",  32'(sw.o_Enable),    32'd0);
        chk("midrst_clr", 32'(sw.o_Clear),     32'd0);
        repeat (2) step();
        i_Rst = 1'b0;
        push_press(cyc, 8, 1'b0);
        repeat (8) step();
        sw.i_Switch = 1'b0;
        repeat (10) step();

        chk("final_en", 32'(sw.o_Enable), 32'(m_en));
        chk("q_empty",  32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
